// File: rtl/quad_port_scheduler_pkg.sv
// Shared types and helpers for the quad-port memory scheduler.
package qps_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } qps_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/quad_port_scheduler_rr_pick2.sv
// Round-robin picker: first and second eligible requesters scanning upward from i_ptr.
module rr_pick2 #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    input  logic [N-1:0]  i_excl,
    output logic [N-1:0]  o_gnt_first,
    output logic [N-1:0]  o_gnt_second,
    output logic          o_vld_first,
    output logic          o_vld_second,
    output logic [IW-1:0] o_idx_first,
    output logic [IW-1:0] o_idx_second,
    output logic [IW-1:0] o_next_first,
    output logic [IW-1:0] o_next_second
);

    logic [N-1:0]  w_cand;
    logic [IW-1:0] w_pos;

    assign w_cand = i_req & ~i_excl;

    always_comb begin
        o_gnt_first   = '0;
        o_gnt_second  = '0;
        o_vld_first   = 1'b0;
        o_vld_second  = 1'b0;
        o_idx_first   = '0;
        o_idx_second  = '0;
        o_next_first  = '0;
        o_next_second = '0;
        w_pos         = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_pos = IW'((32'(i_ptr) + k) % N);
            if (w_cand[w_pos]) begin
                if (!o_vld_first) begin
                    o_vld_first          = 1'b1;
                    o_gnt_first[w_pos]   = 1'b1;
                    o_idx_first          = w_pos;
                    o_next_first         = IW'((32'(w_pos) + 1) % N);
                end else if (!o_vld_second) begin
                    o_vld_second         = 1'b1;
                    o_gnt_second[w_pos]  = 1'b1;
                    o_idx_second         = w_pos;
                    o_next_second        = IW'((32'(w_pos) + 1) % N);
                end
            end
        end
    end

endmodule

// File: rtl/quad_port_scheduler.sv
// Shares a 2-write/2-read memory among NUM_CLIENTS requesters with round-robin grants,
// tagged read returns, and a zero sweep after reset or on clr_start.
module quad_port_scheduler
    import qps_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned RD_LATENCY  = 2,
    parameter int unsigned ID_WIDTH    = clog2(NUM_CLIENTS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clr_start,
    output logic                              init_busy,
    input  logic [NUM_CLIENTS-1:0]            wr_req,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_CLIENTS-1:0]            wr_gnt,
    input  logic [NUM_CLIENTS-1:0]            rd_req,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_CLIENTS-1:0]            rd_gnt,
    output logic                              rsp_a_valid,
    output logic [ID_WIDTH-1:0]               rsp_a_id,
    output logic [DATA_WIDTH-1:0]             rsp_a_data,
    output logic                              rsp_b_valid,
    output logic [ID_WIDTH-1:0]               rsp_b_id,
    output logic [DATA_WIDTH-1:0]             rsp_b_data,
    output logic                              mem_we_a,
    output logic                              mem_we_b,
    output logic [ADDR_WIDTH-1:0]             mem_wraddr_a,
    output logic [ADDR_WIDTH-1:0]             mem_wraddr_b,
    output logic [DATA_WIDTH-1:0]             mem_wrdat_a,
    output logic [DATA_WIDTH-1:0]             mem_wrdat_b,
    output logic [ADDR_WIDTH-1:0]             mem_rdaddr_a,
    output logic [ADDR_WIDTH-1:0]             mem_rdaddr_b,
    input  logic [DATA_WIDTH-1:0]             mem_rddat_a,
    input  logic [DATA_WIDTH-1:0]             mem_rddat_b
);

    localparam int unsigned NUM_PAIRS = (1 << ADDR_WIDTH) / 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(NUM_PAIRS - 1);

    qps_state_e              r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_k, w_k_nxt;
    logic                    r_init_busy;
    logic                    w_run;
    logic [ID_WIDTH-1:0]     r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [ADDR_WIDTH-1:0]   w_sweep_addr;

    logic [ADDR_WIDTH-1:0]   w_wr_addr_arr [NUM_CLIENTS];
    logic [DATA_WIDTH-1:0]   w_wr_data_arr [NUM_CLIENTS];
    logic [ADDR_WIDTH-1:0]   w_rd_addr_arr [NUM_CLIENTS];

    logic [NUM_CLIENTS-1:0]  w_wr_excl, w_wr_gf, w_wr_gs;
    logic                    w_wr_vf, w_wr_vs, w_wr_conflict, w_wr_ok_a, w_wr_ok_b;
    logic [ID_WIDTH-1:0]     w_wr_idx_a, w_wr_idx_b, w_wr_nf, w_wr_ns;
    logic [ADDR_WIDTH-1:0]   w_wr_addr_a, w_wr_addr_b;

    logic [NUM_CLIENTS-1:0]  w_rd_excl, w_rd_gf, w_rd_gs;
    logic                    w_rd_vf, w_rd_vs, w_rd_ok_a, w_rd_ok_b;
    logic [ID_WIDTH-1:0]     w_rd_idx_a, w_rd_idx_b, w_rd_nf, w_rd_ns;

    logic [RD_LATENCY:0]                r_tag_vld_a, r_tag_vld_b;
    logic [RD_LATENCY:0][ID_WIDTH-1:0]  r_tag_id_a, r_tag_id_b;

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
        assign w_wr_addr_arr[g] = wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wr_data_arr[g] = wr_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_rd_addr_arr[g] = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        // A read colliding with a write granted this cycle is skipped, letting the scan continue.
        assign w_rd_excl[g] = (w_wr_ok_a && (w_rd_addr_arr[g] == w_wr_addr_a)) ||
                              (w_wr_ok_b && (w_rd_addr_arr[g] == w_wr_addr_b));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        case (r_state)
            ST_INIT: begin
                w_k_nxt = r_k + 1'b1;
                if (r_k == LAST_K) begin
                    w_state_nxt = ST_RUN;
                    w_k_nxt     = '0;
                end
            end
            ST_RUN: begin
                if (clr_start) begin
                    w_state_nxt = ST_INIT;
                    w_k_nxt     = '0;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Grants wait until the registered busy flag drops so init_busy and gnts never overlap.
    assign w_run     = (r_state == ST_RUN) && !r_init_busy;
    assign w_wr_excl = '0;

    rr_pick2 #(.N(NUM_CLIENTS), .IW(ID_WIDTH)) u_wr_pick (
        .i_req(wr_req), .i_ptr(r_wr_ptr), .i_excl(w_wr_excl),
        .o_gnt_first(w_wr_gf), .o_gnt_second(w_wr_gs),
        .o_vld_first(w_wr_vf), .o_vld_second(w_wr_vs),
        .o_idx_first(w_wr_idx_a), .o_idx_second(w_wr_idx_b),
        .o_next_first(w_wr_nf), .o_next_second(w_wr_ns)
    );

    assign w_wr_addr_a   = w_wr_addr_arr[w_wr_idx_a];
    assign w_wr_addr_b   = w_wr_addr_arr[w_wr_idx_b];
    assign w_wr_conflict = w_wr_vs && (w_wr_addr_a == w_wr_addr_b);
    assign w_wr_ok_a     = w_run && w_wr_vf;
    assign w_wr_ok_b     = w_run && w_wr_vs && !w_wr_conflict;
    assign wr_gnt        = (w_wr_ok_a ? w_wr_gf : '0) | (w_wr_ok_b ? w_wr_gs : '0);
    assign w_wr_ptr_nxt  = w_wr_ok_b ? w_wr_ns : (w_wr_ok_a ? w_wr_nf : r_wr_ptr);

    rr_pick2 #(.N(NUM_CLIENTS), .IW(ID_WIDTH)) u_rd_pick (
        .i_req(rd_req), .i_ptr(r_rd_ptr), .i_excl(w_rd_excl),
        .o_gnt_first(w_rd_gf), .o_gnt_second(w_rd_gs),
        .o_vld_first(w_rd_vf), .o_vld_second(w_rd_vs),
        .o_idx_first(w_rd_idx_a), .o_idx_second(w_rd_idx_b),
        .o_next_first(w_rd_nf), .o_next_second(w_rd_ns)
    );

    assign w_rd_ok_a    = w_run && w_rd_vf;
    assign w_rd_ok_b    = w_run && w_rd_vs;
    assign rd_gnt       = (w_rd_ok_a ? w_rd_gf : '0) | (w_rd_ok_b ? w_rd_gs : '0);
    assign w_rd_ptr_nxt = w_rd_ok_b ? w_rd_ns : (w_rd_ok_a ? w_rd_nf : r_rd_ptr);

    assign w_sweep_addr = ADDR_WIDTH'({r_k, 1'b0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_init_busy  <= 1'b0;
            mem_we_a     <= 1'b0;
            mem_we_b     <= 1'b0;
            mem_wraddr_a <= '0;
            mem_wraddr_b <= '0;
            mem_wrdat_a  <= '0;
            mem_wrdat_b  <= '0;
            mem_rdaddr_a <= '0;
            mem_rdaddr_b <= '0;
            r_tag_vld_a  <= '0;
            r_tag_vld_b  <= '0;
            r_tag_id_a   <= '0;
            r_tag_id_b   <= '0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_init_busy <= (r_state == ST_INIT);
            if (r_state == ST_INIT) begin
                mem_we_a     <= 1'b1;
                mem_we_b     <= 1'b1;
                mem_wraddr_a <= w_sweep_addr;
                mem_wraddr_b <= w_sweep_addr | ADDR_WIDTH'(1);
                mem_wrdat_a  <= '0;
                mem_wrdat_b  <= '0;
                mem_rdaddr_a <= '0;
                mem_rdaddr_b <= '0;
            end else begin
                mem_we_a     <= w_wr_ok_a;
                mem_we_b     <= w_wr_ok_b;
                mem_wraddr_a <= w_wr_ok_a ? w_wr_addr_a : '0;
                mem_wraddr_b <= w_wr_ok_b ? w_wr_addr_b : '0;
                mem_wrdat_a  <= w_wr_ok_a ? w_wr_data_arr[w_wr_idx_a] : '0;
                mem_wrdat_b  <= w_wr_ok_b ? w_wr_data_arr[w_wr_idx_b] : '0;
                mem_rdaddr_a <= w_rd_ok_a ? w_rd_addr_arr[w_rd_idx_a] : '0;
                mem_rdaddr_b <= w_rd_ok_b ? w_rd_addr_arr[w_rd_idx_b] : '0;
            end
            // Tags shift regardless of state so reads in flight across clr_start still return.
            r_tag_vld_a <= {r_tag_vld_a[RD_LATENCY-1:0], w_rd_ok_a};
            r_tag_vld_b <= {r_tag_vld_b[RD_LATENCY-1:0], w_rd_ok_b};
            r_tag_id_a  <= {r_tag_id_a[RD_LATENCY-1:0], w_rd_idx_a};
            r_tag_id_b  <= {r_tag_id_b[RD_LATENCY-1:0], w_rd_idx_b};
        end
    end

    assign init_busy   = r_init_busy;
    assign rsp_a_valid = r_tag_vld_a[RD_LATENCY];
    assign rsp_b_valid = r_tag_vld_b[RD_LATENCY];
    assign rsp_a_id    = rsp_a_valid ? r_tag_id_a[RD_LATENCY] : '0;
    assign rsp_b_id    = rsp_b_valid ? r_tag_id_b[RD_LATENCY] : '0;
    assign rsp_a_data  = rsp_a_valid ? mem_rddat_a : '0;
    assign rsp_b_data  = rsp_b_valid ? mem_rddat_b : '0;

endmodule

// File: tb/tb_quad_port_scheduler.sv
// Randomized scoreboard bench for quad_port_scheduler with a behavioural arbitration/memory model.
module tb_quad_port_scheduler;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int RL = 2;
    localparam int IW = 2;
    localparam int NW = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_start = 1'b0;
    logic init_busy;
    logic [N-1:0] wr_req, wr_gnt, rd_req, rd_gnt;
    logic [N*AW-1:0] wr_addr, rd_addr;
    logic [N*DW-1:0] wr_data;
    logic rsp_a_valid, rsp_b_valid;
    logic [IW-1:0] rsp_a_id, rsp_b_id;
    logic [DW-1:0] rsp_a_data, rsp_b_data;
    logic mem_we_a, mem_we_b;
    logic [AW-1:0] mem_wraddr_a, mem_wraddr_b, mem_rdaddr_a, mem_rdaddr_b;
    logic [DW-1:0] mem_wrdat_a, mem_wrdat_b, mem_rddat_a, mem_rddat_b;

    logic [AW-1:0] wa_arr [N];
    logic [AW-1:0] ra_arr [N];
    logic [DW-1:0] wd_arr [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign wr_addr[g*AW +: AW] = wa_arr[g];
        assign rd_addr[g*AW +: AW] = ra_arr[g];
        assign wr_data[g*DW +: DW] = wd_arr[g];
    end

    quad_port_scheduler #(
        .NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RL), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .init_busy(init_busy),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rsp_a_valid(rsp_a_valid), .rsp_a_id(rsp_a_id), .rsp_a_data(rsp_a_data),
        .rsp_b_valid(rsp_b_valid), .rsp_b_id(rsp_b_id), .rsp_b_data(rsp_b_data),
        .mem_we_a(mem_we_a), .mem_we_b(mem_we_b),
        .mem_wraddr_a(mem_wraddr_a), .mem_wraddr_b(mem_wraddr_b),
        .mem_wrdat_a(mem_wrdat_a), .mem_wrdat_b(mem_wrdat_b),
        .mem_rdaddr_a(mem_rdaddr_a), .mem_rdaddr_b(mem_rdaddr_b),
        .mem_rddat_a(mem_rddat_a), .mem_rddat_b(mem_rddat_b)
    );

    always #5 clk = ~clk;

    // Memory stand-in: two-cycle read pipeline, writes land at the clock edge.
    logic [DW-1:0] mem [NW];
    logic [DW-1:0] p1_a, p1_b;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) mem[i] <= $urandom;
        end else begin
            p1_a <= mem[mem_rdaddr_a];
            p1_b <= mem[mem_rdaddr_b];
            mem_rddat_a <= p1_a;
            mem_rddat_b <= p1_b;
            if (mem_we_a) mem[mem_wraddr_a] <= mem_wrdat_a;
            if (mem_we_b) mem[mem_wraddr_b] <= mem_wrdat_b;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    logic [DW-1:0] rmem [NW];
    int wp = 0;
    int rp = 0;
    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: scan from the pointer, first two eligible win; ptr follows the last winner.
    task automatic model_step(output logic [N-1:0] ewg, output logic [N-1:0] erg);
        int wsel[$];
        int rsel[$];
        int idx;
        bit clash;
        ewg = '0;
        erg = '0;
        for (int k = 0; k < N; k++) begin
            idx = (wp + k) % N;
            if (wr_req[idx] && wsel.size() < 2) wsel.push_back(idx);
        end
        if (wsel.size() == 2 && wa_arr[wsel[0]] == wa_arr[wsel[1]]) wsel.delete(1);
        for (int k = 0; k < N; k++) begin
            idx = (rp + k) % N;
            clash = 1'b0;
            foreach (wsel[j]) if (ra_arr[idx] == wa_arr[wsel[j]]) clash = 1'b1;
            if (rd_req[idx] && !clash && rsel.size() < 2) rsel.push_back(idx);
        end
        foreach (wsel[j]) ewg[wsel[j]] = 1'b1;
        foreach (rsel[j]) erg[rsel[j]] = 1'b1;
        if (rsel.size() > 0) qa.push_back('{rsel[0], rmem[ra_arr[rsel[0]]], cyc});
        if (rsel.size() > 1) qb.push_back('{rsel[1], rmem[ra_arr[rsel[1]]], cyc});
        foreach (wsel[j]) rmem[wa_arr[wsel[j]]] = wd_arr[wsel[j]];
        if (wsel.size() > 0) wp = (wsel[wsel.size()-1] + 1) % N;
        if (rsel.size() > 0) rp = (rsel[rsel.size()-1] + 1) % N;
    endtask

    // Called at a negedge with inputs set; checks grants and returns at the next negedge.
    task automatic run_cycle();
        logic [N-1:0] ewg, erg;
        #2;
        model_step(ewg, erg);
        check("wr_gnt", wr_gnt, ewg);
        check("rd_gnt", rd_gnt, erg);
        @(negedge clk);
    endtask

    task automatic set_idle();
        wr_req = '0;
        rd_req = '0;
        clr_start = 1'b0;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < N; i++) begin
            wr_req[i] = 1'($urandom_range(0, 1));
            rd_req[i] = 1'($urandom_range(0, 1));
            wa_arr[i] = AW'($urandom_range(0, 7));
            ra_arr[i] = AW'($urandom_range(0, 7));
            wd_arr[i] = $urandom;
        end
    endtask

    task automatic watch_init();
        int busy;
        bit done;
        busy = 0;
        done = 1'b0;
        wr_req = '1;
        rd_req = '1;
        clr_start = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            #1;
            if (init_busy) begin
                check("init_we", {mem_we_a, mem_we_b}, 2'b11);
                check("init_wraddr_a", mem_wraddr_a, 2 * busy);
                check("init_wraddr_b", mem_wraddr_b, 2 * busy + 1);
                check("init_wrdat", {mem_wrdat_a, mem_wrdat_b}, 64'd0);
                check("init_gnt", {wr_gnt, rd_gnt}, 8'd0);
                busy++;
            end else if (busy > 0) begin
                done = 1'b1;
                set_idle();
            end else begin
                check("init_pre_gnt", {wr_gnt, rd_gnt}, 8'd0);
            end
        end
        check("init_cycles", busy, 16);
        set_idle();
        for (int i = 0; i < NW; i++) rmem[i] = '0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t ea, eb;
        if (rsp_a_valid) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_a_unexpected actual_id=%0d required=none", rsp_a_id);
            end else begin
                ea = qa.pop_front();
                check("rsp_a_id", rsp_a_id, ea.id);
                check("rsp_a_data", rsp_a_data, ea.data);
                check("rsp_a_latency", cyc - ea.cyc, RL + 1);
            end
        end
        if (rsp_b_valid) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_b_unexpected actual_id=%0d required=none", rsp_b_id);
            end else begin
                eb = qb.pop_front();
                check("rsp_b_id", rsp_b_id, eb.id);
                check("rsp_b_data", rsp_b_data, eb.data);
                check("rsp_b_latency", cyc - eb.cyc, RL + 1);
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            wa_arr[i] = '0;
            ra_arr[i] = '0;
            wd_arr[i] = '0;
        end
        set_idle();
        repeat (3) @(negedge clk);
        check("reset_outputs", {init_busy, rsp_a_valid, rsp_b_valid, mem_we_a, mem_we_b}, 5'd0);
        check("reset_gnts", {wr_gnt, rd_gnt}, 8'd0);
        rst_n = 1'b1;
        watch_init();

        // Four writers with distinct addresses alternate pairs.
        for (int i = 0; i < N; i++) begin
            wa_arr[i] = AW'(10 + i);
            wd_arr[i] = $urandom;
        end
        wr_req = 4'b1111;
        #1 check("t2_gnt0", wr_gnt, 4'b0011);
        run_cycle();
        #1 check("t2_gnt1", wr_gnt, 4'b1100);
        run_cycle();
        #1 check("t2_gnt2", wr_gnt, 4'b0011);
        run_cycle();

        // Same-address pair: only the first is granted, then the other.
        wr_req = 4'b0011;
        wa_arr[0] = 7;
        wa_arr[1] = 7;
        wd_arr[0] = 32'hA0A0_0000;
        wd_arr[1] = 32'hA1A1_1111;
        #1 check("t3_gnt0", wr_gnt, 4'b0001);
        run_cycle();
        #1 check("t3_gnt1", wr_gnt, 4'b0010);
        run_cycle();

        // Read colliding with a same-cycle write is held off, then returns new data.
        set_idle();
        wr_req = 4'b0100;
        wa_arr[2] = 5;
        wd_arr[2] = 32'h5555_C0DE;
        rd_req = 4'b1000;
        ra_arr[3] = 5;
        #1 check("t4_wr", wr_gnt, 4'b0100);
        check("t4_rd_blocked", rd_gnt, 4'b0000);
        run_cycle();
        wr_req = '0;
        #1 check("t4_rd_next", rd_gnt, 4'b1000);
        run_cycle();

        // Two reads on both lanes in one cycle.
        set_idle();
        rd_req = 4'b1010;
        ra_arr[1] = 3;
        ra_arr[3] = 9;
        #1 check("t5_rd", rd_gnt, 4'b1010);
        run_cycle();
        set_idle();
        repeat (4) run_cycle();

        // clr_start with two reads in flight.
        rd_req = 4'b0101;
        ra_arr[0] = 10;
        ra_arr[2] = 7;
        clr_start = 1'b1;
        #1 check("t6_rd", rd_gnt, 4'b0101);
        run_cycle();
        set_idle();
        watch_init();

        for (int c = 0; c < 300; c++) begin
            randomize_inputs();
            run_cycle();
        end
        set_idle();
        repeat (5) run_cycle();

        // Reset with reads in flight: tags dropped, nothing returns.
        for (int c = 0; c < 3; c++) begin
            randomize_inputs();
            wr_req = '0;
            rd_req = 4'b1111;
            run_cycle();
        end
        set_idle();
        #2 rst_n = 1'b0;
        #1 check("midrst_outputs", {rsp_a_valid, rsp_b_valid, init_busy, mem_we_a, mem_we_b}, 5'd0);
        qa.delete();
        qb.delete();
        wp = 0;
        rp = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        watch_init();

        for (int c = 0; c < 150; c++) begin
            randomize_inputs();
            run_cycle();
        end
        set_idle();
        repeat (8) run_cycle();
        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
